// File: rtl/layer_hdr_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// layer_hdr_pkg : widths, defaults and FSM states for layer_header_ctrl
// Revision      : 1.0
// ---------------------------------------------------------------------------
package layer_hdr_pkg;

    localparam int LAYER_W        = 5;
    localparam int REG_W          = 3;
    localparam int DATA_W         = 16;
    localparam int NUM_LAYERS_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_CAP  = 3'd3,
        ST_ACK     = 3'd4,
        ST_CLR     = 3'd5,
        ST_CLR_ALL = 3'd6
    } hdr_state_e;

endpackage
`default_nettype wire

// File: rtl/layer_header_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// layer_header_ctrl : host access and layer-clear sequencer for layer headers.
// Optional clear-all sequencer enabled by defining LAYER_HDR_CLEAR_ALL_EN.
// Revision          : 1.0
// ---------------------------------------------------------------------------
module layer_header_ctrl
    import layer_hdr_pkg::*;
#(
    parameter int NUM_LAYERS = NUM_LAYERS_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hostReq,
    input  logic               hostWrite,
    input  logic [LAYER_W-1:0] hostLayer,
    input  logic [REG_W-1:0]   hostReg,
    input  logic [DATA_W-1:0]  hostWData,
    output logic               hostAck,
    output logic [DATA_W-1:0]  hostRData,
    input  logic               clearLayerReq,
    input  logic [LAYER_W-1:0] clearLayer,
    input  logic               clearAllReq,
    output logic               clearBusy,
    output logic               clearDone,
    output logic               resetLayerEn,
    output logic [LAYER_W-1:0] readWriteLayerCtrl,
    output logic [REG_W-1:0]   ctrlLayerRegister,
    output logic               ctrlWriteEn,
    output logic [DATA_W-1:0]  ctrlWriteData,
    input  logic [DATA_W-1:0]  ctrlReadData
);

    hdr_state_e         state_q, state_d;
    logic               pend_one_q, pend_one_d;
    logic [LAYER_W-1:0] pend_lyr_q, pend_lyr_d;
    logic               ack_q, ack_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rle_q, rle_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic [REG_W-1:0]   reg_q, reg_d;
    logic               wen_q, wen_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               w_one_req;

`ifdef LAYER_HDR_CLEAR_ALL_EN
    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

    logic               pend_all_q, pend_all_d;
    logic [LAYER_W-1:0] cnt_q, cnt_d;
    logic               w_all_req;

    // A pulse arriving in IDLE is served at once, so treat it as pending now
    assign w_all_req = pend_all_q | clearAllReq;
`else
    logic unused_cfg;
    assign unused_cfg = clearAllReq ^ (NUM_LAYERS > NUM_LAYERS_DEF);
`endif

    assign w_one_req = pend_one_q | clearLayerReq;

    always_comb begin
        state_d    = state_q;
        pend_one_d = pend_one_q | clearLayerReq;
        pend_lyr_d = clearLayerReq ? clearLayer : pend_lyr_q;
        ack_d      = 1'b0;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
        rle_d      = 1'b1;
        layer_d    = layer_q;
        reg_d      = reg_q;
        wen_d      = 1'b0;
        wdata_d    = wdata_q;
`ifdef LAYER_HDR_CLEAR_ALL_EN
        pend_all_d = pend_all_q | clearAllReq;
        cnt_d      = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
`ifdef LAYER_HDR_CLEAR_ALL_EN
                if (w_all_req) begin
                    state_d    = ST_CLR_ALL;
                    pend_all_d = 1'b0;
                    cnt_d      = '0;
                    layer_d    = '0;
                    rle_d      = 1'b0;
                end else
`endif
                if (w_one_req) begin
                    state_d    = ST_CLR;
                    pend_one_d = 1'b0;
                    layer_d    = pend_lyr_d;
                    rle_d      = 1'b0;
                end else if (hostReq) begin
                    layer_d = hostLayer;
                    reg_d   = hostReg;
                    wdata_d = hostWData;
                    if (hostWrite) begin
                        state_d = ST_WR;
                        wen_d   = 1'b1;
                    end else begin
                        state_d = ST_RD_ADDR;
                    end
                end
            end
            ST_WR: begin
                state_d = ST_ACK;
                ack_d   = 1'b1;
            end
            ST_RD_ADDR: begin
                state_d = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                state_d = ST_ACK;
                ack_d   = 1'b1;
                rdata_d = ctrlReadData;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            ST_CLR: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
`ifdef LAYER_HDR_CLEAR_ALL_EN
            ST_CLR_ALL: begin
                if (cnt_q == LAST_LAYER) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 5'd1;
                    layer_d = cnt_q + 5'd1;
                    rle_d   = 1'b0;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef LAYER_HDR_CLEAR_ALL_EN
        busy_d = pend_one_d | pend_all_d | (state_d == ST_CLR) | (state_d == ST_CLR_ALL);
`else
        busy_d = pend_one_d | (state_d == ST_CLR);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pend_one_q <= 1'b0;
            pend_lyr_q <= '0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rle_q      <= 1'b1;
            layer_q    <= '0;
            reg_q      <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            pend_one_q <= pend_one_d;
            pend_lyr_q <= pend_lyr_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rle_q      <= rle_d;
            layer_q    <= layer_d;
            reg_q      <= reg_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
        end
    end

`ifdef LAYER_HDR_CLEAR_ALL_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_all_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pend_all_q <= pend_all_d;
            cnt_q      <= cnt_d;
        end
    end
`endif

    assign hostAck            = ack_q;
    assign hostRData          = rdata_q;
    assign clearBusy          = busy_q;
    assign clearDone          = done_q;
    assign resetLayerEn       = rle_q;
    assign readWriteLayerCtrl = layer_q;
    assign ctrlLayerRegister  = reg_q;
    assign ctrlWriteEn        = wen_q;
    assign ctrlWriteData      = wdata_q;

endmodule
`default_nettype wire
